// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared register-file write-back types and constants
package wb_arbiter_pkg;
  localparam int RegBus = 32;
  localparam int RegAddrBus = 5;
  localparam logic WriteEnable = 1'b1;
  localparam logic RstEnable = 1'b1;
  localparam logic [RegBus-1:0] ZeroWord = '0;
  localparam int WbQDepth = 2;
  typedef struct packed {
    logic v;
    logic [RegAddrBus-1:0] a;
    logic [RegBus-1:0] d;
  } wb_ent_t;
endpackage

// File: rtl/wb_queue.sv
// wb_queue: late-write FIFO with per-entry valid bits, WAW invalidation and address lookup
module wb_queue
  import wb_arbiter_pkg::*;
#(
  parameter int QDEPTH = WbQDepth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [RegAddrBus-1:0] push_addr_i,
  input  logic [RegBus-1:0]     push_data_i,
  input  logic                  pop_i,
  input  logic                  inv_en_i,
  input  logic [RegAddrBus-1:0] inv_addr_i,
  input  logic [RegAddrBus-1:0] raddr_i,
  output logic                  ready_o,
  output logic                  empty_o,
  output logic                  hit_o,
  output wb_ent_t               head_o
);
  localparam int PW = $clog2(QDEPTH);
  wb_ent_t mem_q [QDEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign ready_o = cnt_q < (PW+1)'(QDEPTH);
  assign empty_o = cnt_q == '0;
  assign head_o = mem_q[rptr_q];
  assign do_push = push_i && ready_o;
  assign do_pop = pop_i && !empty_o;
  always_comb begin
    wptr_d = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = do_pop ? rptr_q + 1'b1 : rptr_q;
    cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    hit_o = 1'b0;
    for (int i = 0; i < QDEPTH; i++) hit_o = hit_o | (mem_q[i].v && mem_q[i].a == raddr_i);
    hit_o = hit_o && raddr_i != '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < QDEPTH; i++) if (inv_en_i && mem_q[i].a == inv_addr_i) mem_q[i].v <= 1'b0;
      if (do_pop) mem_q[rptr_q].v <= 1'b0;
      // an entry overtaken by a same-cycle pipeline write to its register is born dead
      if (do_push) mem_q[wptr_q] <= {!(inv_en_i && inv_addr_i == push_addr_i), push_addr_i, push_data_i};
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write port shared by the pipeline and queued late results
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int QDEPTH = WbQDepth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_wreg,
  input  logic [RegAddrBus-1:0] pipe_wd,
  input  logic [RegBus-1:0]     pipe_wdata,
  input  logic                  flush,
  input  logic                  div_valid,
  input  logic [RegAddrBus-1:0] div_wd,
  input  logic [RegBus-1:0]     div_wdata,
  output logic                  div_ready,
  input  logic [RegAddrBus-1:0] pend_raddr,
  output logic                  pend_hit,
  output logic                  we,
  output logic [RegAddrBus-1:0] waddr,
  output logic [RegBus-1:0]     wdata
);
  logic acc, pop, empty, hv;
  wb_ent_t head;
  logic we_q, we_d;
  logic [RegAddrBus-1:0] waddr_q, waddr_d;
  logic [RegBus-1:0] wdata_q, wdata_d;
  assign acc = pipe_wreg && pipe_wd != '0 && !flush;
  assign pop = !acc && !empty;
  assign hv = pop && head.v;
  wb_queue #(.QDEPTH(QDEPTH)) u_q (
    .clk(clk), .rst(rst),
    .push_i(div_valid && div_wd != '0), .push_addr_i(div_wd), .push_data_i(div_wdata),
    .pop_i(pop), .inv_en_i(acc), .inv_addr_i(pipe_wd), .raddr_i(pend_raddr),
    .ready_o(div_ready), .empty_o(empty), .hit_o(pend_hit), .head_o(head)
  );
  always_comb begin
    we_d = acc ? WriteEnable : hv;
    waddr_d = acc ? pipe_wd : hv ? head.a : '0;
    wdata_d = acc ? pipe_wdata : hv ? head.d : ZeroWord;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= ZeroWord;
    end else begin
      we_q <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end
  assign we = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: vector table, reset corner sequence and random model-driven scoreboard
module tb_wb_arbiter;
  localparam int QD = 2;
  logic clk = 1'b0, rst;
  logic pipe_wreg, flush, div_valid, div_ready, pend_hit, we;
  logic [4:0] pipe_wd, div_wd, pend_raddr, waddr;
  logic [31:0] pipe_wdata, div_wdata, wdata;
  int nvec = 0, nerr = 0;

  typedef struct {
    logic wreg; logic [4:0] wd; logic [31:0] wdat; logic fl;
    logic dv; logic [4:0] dwd; logic [31:0] ddat; logic [4:0] ra;
    logic rdy; logic hit; logic we; logic [4:0] wa; logic [31:0] wdd;
  } vec_t;
  typedef struct { logic [4:0] a; logic [31:0] d; logic v; } ent_t;
  vec_t tbl[$];
  logic [37:0] sb[$];
  ent_t mq[$];

  wb_arbiter #(.QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .pipe_wreg(pipe_wreg), .pipe_wd(pipe_wd), .pipe_wdata(pipe_wdata),
    .flush(flush), .div_valid(div_valid), .div_wd(div_wd), .div_wdata(div_wdata),
    .div_ready(div_ready), .pend_raddr(pend_raddr), .pend_hit(pend_hit),
    .we(we), .waddr(waddr), .wdata(wdata)
  );
  always #5 clk = ~clk;

  function automatic vec_t mkv(int wreg, int wd, int wdat, int fl, int dv, int dwd, int ddat, int ra,
                               int rdy, int hit, int xwe, int wa, int wdd);
    vec_t r;
    r.wreg = 1'(wreg); r.wd = 5'(wd); r.wdat = wdat; r.fl = 1'(fl);
    r.dv = 1'(dv); r.dwd = 5'(dwd); r.ddat = ddat; r.ra = 5'(ra);
    r.rdy = 1'(rdy); r.hit = 1'(hit); r.we = 1'(xwe); r.wa = 5'(wa); r.wdd = wdd;
    return r;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", n, a, e, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    logic [37:0] x;
    pipe_wreg = v.wreg; pipe_wd = v.wd; pipe_wdata = v.wdat; flush = v.fl;
    div_valid = v.dv; div_wd = v.dwd; div_wdata = v.ddat; pend_raddr = v.ra;
    #2;
    chk("div_ready", 32'(div_ready), 32'(v.rdy));
    chk("pend_hit", 32'(pend_hit), 32'(v.hit));
    sb.push_back({v.we, v.wa, v.wdd});
    @(posedge clk); #1;
    x = sb.pop_front();
    chk("we", 32'(we), 32'(x[37]));
    chk("waddr", 32'(waddr), 32'(x[36:32]));
    chk("wdata", wdata, x[31:0]);
  endtask

  initial begin
    rst = 1'b1;
    {pipe_wreg, pipe_wd, pipe_wdata, flush, div_valid, div_wd, div_wdata, pend_raddr} = '0;
    //             wreg wd wdat        fl dv dwd ddat         ra rdy hit we wa wdd
    tbl.push_back(mkv(0, 0, 0,           0, 0, 0, 0,           0, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 5, 'h12345678,  0, 0, 0, 0,           0, 1, 0, 1, 5, 'h12345678));
    tbl.push_back(mkv(1, 5, 'hdead,      1, 0, 0, 0,           0, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 'hffff,      0, 0, 0, 0,           0, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0,           0, 1, 7, 'hA5A5A5A5,  7, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0,           0, 0, 0, 0,           7, 1, 1, 1, 7, 'hA5A5A5A5));
    tbl.push_back(mkv(0, 0, 0,           0, 0, 0, 0,           7, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 3, 'h33,        0, 1, 9, 'h90,        9, 1, 0, 1, 3, 'h33));
    tbl.push_back(mkv(1, 3, 'h34,        0, 1, 9, 'h91,        9, 1, 1, 1, 3, 'h34));
    tbl.push_back(mkv(1, 3, 'h35,        0, 1, 9, 'h92,        9, 0, 1, 1, 3, 'h35));
    tbl.push_back(mkv(0, 0, 0,           0, 1, 9, 'h92,        9, 0, 1, 1, 9, 'h90));
    tbl.push_back(mkv(0, 0, 0,           0, 1, 9, 'h92,        9, 1, 1, 1, 9, 'h91));
    tbl.push_back(mkv(0, 0, 0,           0, 0, 0, 0,           9, 1, 1, 1, 9, 'h92));
    tbl.push_back(mkv(0, 0, 0,           0, 0, 0, 0,           9, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 8, 'h80,        0, 1, 4, 'h44,        4, 1, 0, 1, 8, 'h80));
    tbl.push_back(mkv(1, 4, 'h1,         0, 0, 0, 0,           4, 1, 1, 1, 4, 'h1));
    tbl.push_back(mkv(0, 0, 0,           0, 0, 0, 0,           4, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0,           0, 0, 0, 0,           0, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 6, 'h66,        0, 1, 6, 'h67,        6, 1, 0, 1, 6, 'h66));
    tbl.push_back(mkv(0, 0, 0,           0, 0, 0, 0,           6, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0,           0, 1, 0, 'h123,       0, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0,           0, 0, 0, 0,           0, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 2, 'h2f,        1, 1, 2, 'h22,        2, 1, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0,           0, 0, 0, 0,           2, 1, 1, 1, 2, 'h22));
    tbl.push_back(mkv(0, 0, 0,           0, 0, 0, 0,           2, 1, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 32'(we), 0);
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_ready", 32'(div_ready), 1);
    chk("rst_hit", 32'(pend_hit), 0);
    rst = 1'b0;
    foreach (tbl[i]) apply(tbl[i]);
    // two queued entries then an asynchronous reset between edges
    apply(mkv(1, 3, 1, 0, 1, 10, 'hA0, 10, 1, 0, 1, 3, 1));
    apply(mkv(1, 3, 2, 0, 1, 11, 'hB0, 10, 1, 1, 1, 3, 2));
    pipe_wreg = 1'b0; div_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_we", 32'(we), 0);
    chk("arst_waddr", 32'(waddr), 0);
    chk("arst_wdata", wdata, 0);
    chk("arst_ready", 32'(div_ready), 1);
    chk("arst_hit", 32'(pend_hit), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    apply(mkv(1, 12, 'hC0, 0, 0, 0, 0, 10, 1, 0, 1, 12, 'hC0));
    apply(mkv(0, 0, 0, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0));
    apply(mkv(0, 0, 0, 0, 0, 0, 0, 11, 1, 0, 0, 0, 0));
    for (int n = 0; n < 300; n++) begin
      vec_t v;
      ent_t e;
      logic acc;
      v.wreg = 1'($urandom_range(0, 1)); v.wd = 5'($urandom_range(0, 7)); v.wdat = $urandom;
      v.fl = ($urandom_range(0, 3) == 0); v.dv = 1'($urandom_range(0, 1));
      v.dwd = 5'($urandom_range(0, 7)); v.ddat = $urandom; v.ra = 5'($urandom_range(0, 7));
      v.rdy = mq.size() < QD;
      v.hit = 1'b0;
      foreach (mq[k]) if (mq[k].v && mq[k].a == v.ra && v.ra != 0) v.hit = 1'b1;
      acc = v.wreg && v.wd != 0 && !v.fl;
      {v.we, v.wa, v.wdd} = '0;
      if (acc) {v.we, v.wa, v.wdd} = {1'b1, v.wd, v.wdat};
      else if (mq.size() > 0) begin
        e = mq.pop_front();
        if (e.v) {v.we, v.wa, v.wdd} = {1'b1, e.a, e.d};
      end
      if (acc) foreach (mq[k]) if (mq[k].a == v.wd) mq[k].v = 1'b0;
      if (v.dv && v.rdy && v.dwd != 0) mq.push_back('{v.dwd, v.ddat, !(acc && v.wd == v.dwd)});
      apply(v);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The module SHALL have parameter QDEPTH, default 2, giving the late-write queue depth (power of two, at least 2).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port pipe_wreg, input, 1 bit: the MEM/WB write request.
REQ-005 The module SHALL have port pipe_wd, input, 5 bits: the destination register of the pipeline write.
REQ-006 The module SHALL have port pipe_wdata, input, 32 bits: the data of the pipeline write.
REQ-007 The module SHALL have port flush, input, 1 bit: squash the pipeline write sampled this cycle.
REQ-008 The module SHALL have port div_valid, input, 1 bit: a late (multi-cycle unit) result is offered.
REQ-009 The module SHALL have port div_wd, input, 5 bits: the destination register of the late result.
REQ-010 The module SHALL have port div_wdata, input, 32 bits: the data of the late result.
REQ-011 The module SHALL have port div_ready, output, 1 bit: the queue can accept a late result this cycle.
REQ-012 The module SHALL have port pend_raddr, input, 5 bits: the register address looked up for hazard detection.
REQ-013 The module SHALL have port pend_hit, output, 1 bit: a valid queued write targets pend_raddr.
REQ-014 The module SHALL have port we, output, 1 bit: write enable to the register file write port.
REQ-015 The module SHALL have port waddr, output, 5 bits: write address to the register file.
REQ-016 The module SHALL have port wdata, output, 32 bits: write data to the register file.

Function
REQ-017 Pipeline write accepted in cycle N iff pipe_wreg=1, pipe_wd!=0 and flush=0; it SHALL appear on we/waddr/wdata in cycle N+1 (one-cycle registered latency).
REQ-018 Late result SHALL be pushed iff div_valid=1 and div_ready=1; div_ready SHALL be combinational count<QDEPTH, independent of div_valid.
REQ-019 A late result with div_wd=0 SHALL be consumed (handshake completes) but not enqueued.
REQ-020 Arbitration: an accepted pipeline write SHALL have priority; the queue head SHALL pop to the outputs only in a cycle with no accepted pipeline write.
REQ-021 No bypass: a pushed entry SHALL reach the outputs no earlier than 2 cycles after its push cycle.
REQ-022 A popped head whose valid bit is 0 SHALL be discarded and SHALL produce we=0 in the following cycle.
REQ-023 WAW: an accepted pipeline write to register A SHALL clear the valid bit of every queued entry with address A in the same edge.
REQ-024 WAW: a late result pushed in the same cycle as an accepted pipeline write to the same address SHALL be enqueued invalid.
REQ-025 A cycle with no accepted pipeline write and an empty queue SHALL produce we=0, waddr=0, wdata=0 in the next cycle.
REQ-026 Simultaneous push and pop in one cycle SHALL be legal, including at count=QDEPTH-1, leaving count unchanged.
REQ-027 Pointers SHALL wrap modulo QDEPTH; count SHALL range 0..QDEPTH.
REQ-028 flush SHALL NOT affect queued entries or the handshake.
REQ-029 pend_hit SHALL be combinational and SHALL be 0 when pend_raddr=0.

Reset
REQ-030 rst=1 SHALL immediately clear we, waddr and wdata to 0, empty the queue (count=0, pointers=0, all valid bits 0) and force div_ready=1 and pend_hit=0.
REQ-031 A reset asserted mid-operation SHALL discard queued writes, which are never written.
REQ-032 The first write SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-033 RegBus, RegAddrBus, WriteEnable, RstEnable, ZeroWord and WbQDepth SHALL come from the shared defines.
REQ-034 The queue (storage, valid bits, pointers, count, invalidate-by-address, lookup) SHALL be a sub-module named wb_queue; arbitration and the output register SHALL stay in wb_arbiter.

Verification
REQ-035 Pipeline write: pipe_wreg=1, wd=5, data=0x12345678 at cycle N -> we=1, waddr=5, wdata=0x12345678 at N+1; with flush=1 instead -> we=0 at N+1.
REQ-036 Idle pipeline: push div wd=7, data=0xA5A5A5A5 at N -> pend_hit=1 for raddr=7 from N+1; we=1, waddr=7 at N+2; pend_hit=0 from N+2.
REQ-037 Full queue: hold div_valid with continuous pipeline writes to reg 3 and late wd=9 -> two pushes, then div_ready=0; release the pipeline -> entries written one per cycle and div_ready=1 after the first pop.
REQ-038 WAW: queue holds wd=4, then pipeline write wd=4 data=0x1 -> reg 4 written only with 0x1; the invalid head yields one we=0 cycle.
REQ-039 Reset mid-operation: queue holds 2 entries, assert rst between edges -> we=0 and div_ready=1 immediately; no queued write appears after deassertion.
